// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared types and helpers for serial_shift_controller.
//   state_t       : controller FSM states (IDLE, SHIFT, PAR, GAPW)
//   cnt_width()   : width of the shared bit/gap down-counter
//   even_parity() : XOR reduction of a word (zero-extend narrower words)
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAPW  = 2'd3
  } state_t;

  // The counter must hold both WIDTH-1 (bit index) and GAP-1 (gap length).
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/shift_reg_left.sv
// -----------------------------------------------------------------------------
// shift_reg_left
// WIDTH-bit left-shift register, zero shifted into bit 0.
//   i_clk    : clock
//   i_clr_n  : synchronous active-low clear
//   i_load   : parallel load of i_data (wins over i_shift)
//   i_shift  : shift left by one
//   i_data   : parallel word
//   o_msb    : bit [WIDTH-1] of the register
// -----------------------------------------------------------------------------
module shift_reg_left #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/serial_shift_controller.sv
// -----------------------------------------------------------------------------
// serial_shift_controller
// Accepts a parallel word over valid/ready, shifts it out MSB-first on ser_out
// framed by ser_en, then waits GAP idle cycles before accepting the next word.
// Optional macro SHIFT_PARITY_EN appends an even-parity bit (PAR state).
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   in_data   : parallel word (WIDTH bits)
//   in_valid  : producer offers in_data
//   in_ready  : high only in IDLE
//   ser_out   : serial data, 0 whenever ser_en is low
//   ser_en    : high on every frame bit
//   busy      : high outside IDLE
//   done      : one-cycle pulse right after the last frame bit
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// SHIFT | driving data bits, counter = bits remaining after this one
// PAR   | driving the parity bit (SHIFT_PARITY_EN only)
// GAPW  | idle gap, counter = gap cycles remaining after this one
// -----------------------------------------------------------------------------
module serial_shift_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam state_t AFTER_FRAME = (GAP > 0) ? GAPW : IDLE;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          w_accept;
  logic          w_last_data_bit;
  logic          w_frame_end;
  logic          w_msb;
  logic          w_par_bit;

  assign w_accept        = (r_state == IDLE) && in_valid;
  assign w_last_data_bit = (r_state == SHIFT) && (r_cnt == '0);

`ifdef SHIFT_PARITY_EN
  logic r_par;

  // Parity is taken at acceptance because the shift register loses the word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= even_parity(32'(in_data));
    end
  end

  assign w_par_bit   = r_par;
  assign w_frame_end = (r_state == PAR);
`else
  assign w_par_bit   = 1'b0;
  assign w_frame_end = w_last_data_bit;
`endif

  shift_reg_left #(.WIDTH(WIDTH)) u_shift_reg (
    .i_clk   (clk),
    .i_clr_n (rst),
    .i_load  (w_accept),
    .i_shift (r_state == SHIFT),
    .i_data  (in_data),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == '0) begin
`ifdef SHIFT_PARITY_EN
          w_next_state = PAR;
`else
          w_next_state = AFTER_FRAME;
`endif
        end
      end
      PAR:     w_next_state = AFTER_FRAME;
      GAPW: begin
        if (r_cnt == '0) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    ser_en   = 1'b0;
    ser_out  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      SHIFT: begin
        ser_en  = 1'b1;
        ser_out = w_msb;
      end
      PAR: begin
        ser_en  = 1'b1;
        ser_out = w_par_bit;
      end
      default: begin
        ser_en  = 1'b0;
        ser_out = 1'b0;
      end
    endcase
  end

  // One counter serves both the bit index and the gap length; it is preloaded
  // with GAP-1 while leaving SHIFT/PAR so GAPW sees the right value on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) r_cnt <= BIT_LOAD;
        end
        SHIFT: begin
          if (r_cnt == '0) r_cnt <= GAP_LOAD;
          else             r_cnt <= r_cnt - 1'b1;
        end
        PAR:     r_cnt <= GAP_LOAD;
        GAPW: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
    end
  end

  assign done = r_done;

endmodule
